// File: rtl/fp16_add_arbiter.sv
// Two-requester FP16 add unit: one shared adder, round-robin grant on ties,
// result returned EXEC_CYCLES cycles after accept and held until consumed.
module fp16_add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic [3:0]  flags
);
  logic [15:0] x, y;
  logic [4:0]  ex, ey, d;
  logic [13:0] mx, my, my_sh, norm;
  logic [14:0] acc;
  logic [11:0] mant;
  logic [5:0]  e;
  logic        carry, ovf, rnd, sgn, x_nan, y_nan, x_inf, y_inf;

  always_comb begin
    x  = (a[14:0] >= b[14:0]) ? a : b;
    y  = (a[14:0] >= b[14:0]) ? b : a;
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx = {x[14:10] != 5'd0, x[9:0], 3'b000};
    my = {y[14:10] != 5'd0, y[9:0], 3'b000};
    d  = ex - ey;
    // Align the smaller operand; bits shifted out collapse into a sticky lsb.
    my_sh    = my >> d;
    my_sh[0] = my_sh[0] | (|(my & ((14'h1 << d) - 14'h1)));
    carry = 1'b0;
    if (x[15] == y[15]) begin
      acc   = {1'b0, mx} + {1'b0, my_sh};
      carry = acc[14];
    end else begin
      acc   = {1'b0, mx} - {1'b0, my_sh};
    end
    e = {1'b0, ex};
    if (carry) begin
      norm = {acc[14:2], acc[1] | acc[0]};
      e    = e + 6'd1;
    end else begin
      norm = acc[13:0];
    end
    // Left-normalise, stopping at the minimum exponent so subnormals fall out.
    for (int i = 0; i < 13; i++) begin
      if (!norm[13] && e > 6'd1) begin
        norm = norm << 1;
        e    = e - 6'd1;
      end
    end
    rnd  = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant = {1'b0, norm[13:3]} + {11'd0, rnd};
    if (mant[11]) begin
      mant = mant >> 1;
      e    = e + 6'd1;
    end
    sgn   = (mant == 12'd0 && x[15] != y[15]) ? 1'b0 : x[15];
    x_nan = (&x[14:10]) & (|x[9:0]);
    y_nan = (&y[14:10]) & (|y[9:0]);
    x_inf = (&x[14:10]) & ~(|x[9:0]);
    y_inf = (&y[14:10]) & ~(|y[9:0]);
    ovf   = 1'b0;
    if (x_nan | y_nan | (x_inf & y_inf & (x[15] != y[15]))) begin
      sum   = 16'h7E00;
      carry = 1'b0;
    end else if (x_inf | y_inf) begin
      sum   = {x[15], 15'h7C00};
      carry = 1'b0;
    end else if (e >= 6'd31) begin
      sum = {sgn, 15'h7C00};
      ovf = 1'b1;
    end else begin
      sum = {sgn, mant[10] ? e[4:0] : 5'd0, mant[9:0]};
    end
    flags = {sum[15], sum[14:0] == 15'd0, carry, ovf};
  end
endmodule

module fp16_add_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, add_flags;
  logic [15:0] op_a, op_b, add_sum;
  logic        grant, last_grant, win, accept, done, rsp_hs;

  fp16_add u_add (.a(op_a), .b(op_b), .sum(add_sum), .flags(add_flags));

  always_comb begin
    win       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    done      = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: if (reset && |req_valid) begin
        req_ready = win ? 2'b10 : 2'b01;
        accept    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: if (cnt == LAST_CNT) begin
        done      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = grant ? 2'b10 : 2'b01;
        if (rsp_ready[grant]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 4'd0;
      op_a       <= 16'h0000;
      op_b       <= 16'h0000;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      result     <= 16'h0000;
      flags      <= 4'b0000;
    end else begin
      if (accept) begin
        op_a  <= win ? a1 : a0;
        op_b  <= win ? b1 : b0;
        grant <= win;
        cnt   <= 4'd0;
      end else if (state == EXEC) begin
        cnt <= cnt + 4'd1;
      end
      if (done) begin
        result <= add_sum;
        flags  <= add_flags;
      end
      if (rsp_hs) last_grant <= grant;
    end
  end
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter: reset, tie/round-robin, backpressure,
// mid-operation reset, and a four-cycle latency instance.
module tb_fp16_add_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] a0, b0, a1, b1, result;
  logic [3:0]  flags;
  logic        busy;

  logic [1:0]  req_valid_4, req_ready_4, rsp_valid_4, rsp_ready_4;
  logic [15:0] a0_4, b0_4, a1_4, b1_4, result_4;
  logic [3:0]  flags_4;
  logic        busy_4;

  int checks = 0;
  int errors = 0;

  fp16_add_arbiter #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .result(result), .flags(flags), .busy(busy)
  );

  fp16_add_arbiter #(.EXEC_CYCLES(4)) u_dut_4 (
    .clk(clk), .reset(reset), .req_valid(req_valid_4), .req_ready(req_ready_4),
    .a0(a0_4), .b0(b0_4), .a1(a1_4), .b1(b1_4), .rsp_valid(rsp_valid_4),
    .rsp_ready(rsp_ready_4), .result(result_4), .flags(flags_4), .busy(busy_4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b00;
    a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
    req_valid_4 = 2'b00; rsp_ready_4 = 2'b00;
    a0_4 = 16'h0; b0_4 = 16'h0; a1_4 = 16'h0; b1_4 = 16'h0;

    // Reset held low with both requests pending.
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // First tie after reset goes to requester 0; 1.0+1.0 = 2.0 with mantissa carry.
    reset = 1'b1;
    a0 = 16'h3C00; b0 = 16'h3C00; a1 = 16'hC000; b1 = 16'hBC00;
    #1 check("tie_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b10;
    #1 check("exec_req_ready", 32'(req_ready), 32'h0);
    check("exec_rsp_valid", 32'(rsp_valid), 32'h0);
    check("exec_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_result", 32'(result), 32'h4000);
      check("bp_flags", 32'(flags), 32'h2);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check("hs0_rsp_valid", 32'(rsp_valid), 32'h0);
    check("hs0_busy", 32'(busy), 32'h0);
    check("idle_req1_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 check("req1_rsp_valid", 32'(rsp_valid), 32'h2);
    check("req1_result", 32'(result), 32'hC200);
    check("req1_flags", 32'(flags), 32'h8);
    rsp_ready = 2'b11;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check("hs1_rsp_valid", 32'(rsp_valid), 32'h0);

    // Single request 1.0+2.0 = 3.0; operands changed after accept must not leak in.
    a0 = 16'h3C00; b0 = 16'h4000; req_valid = 2'b01;
    #1 check("single_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00; a0 = 16'h7BFF; b0 = 16'h7BFF;
    #1 check("single_exec_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1 check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_result", 32'(result), 32'h4200);
    check("single_flags", 32'(flags), 32'h0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check("single_hs_rsp", 32'(rsp_valid), 32'h0);

    // Last served was requester 0, so a tie now points at requester 1.
    req_valid = 2'b11;
    #1 check("rr_req_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    @(negedge clk);
    #1 check("rr_no_accept_busy", 32'(busy), 32'h0);

    // Reset during EXEC discards the operation.
    a0 = 16'h3C00; b0 = 16'h3C00; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("mid_busy_before", 32'(busy), 32'h1);
    reset = 1'b0;
    #1 check("mid_busy_rst", 32'(busy), 32'h0);
    check("mid_result_rst", 32'(result), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(rsp_valid), 32'h0);
    end
    check("mid_busy_after", 32'(busy), 32'h0);
    req_valid = 2'b11;
    #1 check("mid_tie_req_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    @(negedge clk);

    // Four-cycle instance: response appears exactly four edges after accept.
    a0_4 = 16'h3C00; b0_4 = 16'h4000; req_valid_4 = 2'b01;
    #1 check("lat4_req_ready", 32'(req_ready_4), 32'h1);
    @(negedge clk);
    req_valid_4 = 2'b00;
    #1 check("lat4_cyc0", 32'(rsp_valid_4), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("lat4_cyc%0d", k), 32'(rsp_valid_4), (k == 4) ? 32'h1 : 32'h0);
    end
    check("lat4_result", 32'(result_4), 32'h4200);
    check("lat4_flags", 32'(flags_4), 32'h0);
    rsp_ready_4 = 2'b01;
    @(negedge clk);
    rsp_ready_4 = 2'b00;
    #1 check("lat4_hs_rsp", 32'(rsp_valid_4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
